// File: rtl/pf_ddr3_cmd_slot_packer_pkg.sv
// Shared command encodings and slot geometry for the DDR3 command slot packer.
package pf_ddr3_cmd_slot_packer_pkg;

    // One fabric clock carries this many command slots on the wire.
    localparam int SLOTS = 4;

    // {RAS_N, CAS_N, WE_N}, active low.
    typedef logic [2:0] cmd_code_t;

    localparam cmd_code_t NOP = 3'b111;
    localparam cmd_code_t ACT = 3'b011;
    localparam cmd_code_t RD  = 3'b101;
    localparam cmd_code_t WR  = 3'b100;
    localparam cmd_code_t PRE = 3'b010;
    localparam cmd_code_t REF = 3'b001;

    // Number of queued entries the packer may consider in one cycle.
    function automatic logic [2:0] eligible_count(input int unsigned level);
        return (level >= SLOTS) ? 3'(SLOTS) : 3'(level);
    endfunction

endpackage

// File: rtl/pf_ddr3_cmd_fifo.sv
// Command queue: single push, 0..4 pops per cycle, head four entries visible
// combinationally from registered storage.
module pf_ddr3_cmd_fifo
    import pf_ddr3_cmd_slot_packer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  cmd_code_t                      push_data,
    input  logic [2:0]                     pop_count,
    output cmd_code_t                      head [SLOTS],
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    cmd_code_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_count);
            level  <= level + LVL_W'(push) - LVL_W'(pop_count);
        end
    end

    // Head window; entries beyond level are don't-care for the packer.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            head[i] = mem[rd_ptr + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/pf_ddr3_cmd_slot_packer.sv
// Packs queued DDR3 commands into 4-slot pin words, keeping a minimum slot
// distance that carries across fabric cycles.
module pf_ddr3_cmd_slot_packer
    import pf_ddr3_cmd_slot_packer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int CMD_SPACING = 1
) (
    input  logic                                FAB_CLK,
    input  logic                                TX_SYNC_RST,
    input  logic                                CMD_VALID,
    output logic                                CMD_READY,
    input  logic [2:0]                          CMD_CODE,
    input  logic                                OE_ENABLE,
    output logic [3:0]                          RAS_N_DATA,
    output logic [3:0]                          CAS_N_DATA,
    output logic [3:0]                          WE_N_DATA,
    output logic [3:0]                          OE_DATA,
    output logic [2:0]                          PACK_COUNT,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     FIFO_LEVEL
);

    localparam int         LVL_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] GAP_RELOAD = 4'(CMD_SPACING - 1);

    logic             in_rst_q;
    logic             push;
    logic [LVL_W-1:0] fifo_level;
    cmd_code_t        head [SLOTS];
    logic [2:0]       avail;
    logic [2:0]       issued;
    logic [3:0]       gap_q;
    logic [3:0]       gap_v;
    cmd_code_t        slot_code [SLOTS];
    logic [3:0]       ras_d;
    logic [3:0]       cas_d;
    logic [3:0]       we_d;

    // Ready stays low through the first edge after reset release.
    assign CMD_READY = !TX_SYNC_RST && !in_rst_q &&
                       (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push       = CMD_VALID && CMD_READY;
    assign FIFO_LEVEL = fifo_level;

    pf_ddr3_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (FAB_CLK),
        .rst       (TX_SYNC_RST),
        .push      (push),
        .push_data (CMD_CODE),
        .pop_count (issued),
        .head      (head),
        .level     (fifo_level)
    );

    // Walk the four slots in wire order, issuing the head whenever the gap
    // counter has expired; only entries registered at cycle start are used.
    always_comb begin
        avail  = eligible_count(32'(fifo_level));
        gap_v  = gap_q;
        issued = 3'd0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_code[s] = NOP;
            if (gap_v == 4'd0 && issued < avail) begin
                slot_code[s] = head[issued[1:0]];
                issued       = issued + 3'd1;
                gap_v        = GAP_RELOAD;
            end else if (gap_v != 4'd0) begin
                gap_v = gap_v - 4'd1;
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            ras_d[s] = slot_code[s][2];
            cas_d[s] = slot_code[s][1];
            we_d[s]  = slot_code[s][0];
        end
    end

    // Registered pin words, gap counter and reset-release tracking.
    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            in_rst_q   <= 1'b1;
            gap_q      <= 4'd0;
            RAS_N_DATA <= 4'hF;
            CAS_N_DATA <= 4'hF;
            WE_N_DATA  <= 4'hF;
            OE_DATA    <= 4'h0;
            PACK_COUNT <= 3'd0;
        end else begin
            in_rst_q   <= 1'b0;
            gap_q      <= gap_v;
            RAS_N_DATA <= ras_d;
            CAS_N_DATA <= cas_d;
            WE_N_DATA  <= we_d;
            OE_DATA    <= {4{OE_ENABLE}};
            PACK_COUNT <= issued;
        end
    end

endmodule

// File: tb/tb_pf_ddr3_cmd_slot_packer.sv
// Bench for the DDR3 command slot packer: three instances with spacing 1, 6
// and 15; a negedge monitor pops an expected-command queue filled on accept.
module tb_pf_ddr3_cmd_slot_packer;
    import pf_ddr3_cmd_slot_packer_pkg::*;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld     [N];
    logic [2:0] code_in [N];
    logic       oe_in   [N];
    logic       rdy     [N];
    logic [3:0] ras     [N];
    logic [3:0] cas     [N];
    logic [3:0] we      [N];
    logic [3:0] oe_out  [N];
    logic [2:0] pc      [N];
    logic [2:0] lvl     [N];

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_dut
        pf_ddr3_cmd_slot_packer #(
            .FIFO_DEPTH  (4),
            .CMD_SPACING ((i == 0) ? 1 : ((i == 1) ? 6 : 15))
        ) u_dut (
            .FAB_CLK     (clk),
            .TX_SYNC_RST (rst),
            .CMD_VALID   (vld[i]),
            .CMD_READY   (rdy[i]),
            .CMD_CODE    (code_in[i]),
            .OE_ENABLE   (oe_in[i]),
            .RAS_N_DATA  (ras[i]),
            .CAS_N_DATA  (cas[i]),
            .WE_N_DATA   (we[i]),
            .OE_DATA     (oe_out[i]),
            .PACK_COUNT  (pc[i]),
            .FIFO_LEVEL  (lvl[i])
        );
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q [$];
    logic [3:0] we_log [$];
    int         sel       = 0;
    int         exact_gap = 0;
    bit         log_en    = 0;
    bit         chk_lvl   = 0;
    int         max_lvl   = 0;
    longint     cyc       = 0;
    longint     last_abs  = 0;
    int         last_sel  = -1;
    logic [2:0] mon_code;
    int         mon_cnt;
    longint     mon_abs;

    function automatic int spacing_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 6 : 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare every issued slot against the scoreboard queue.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mon_cnt = 0;
            for (int s = 0; s < SLOTS; s++) begin
                mon_code = {ras[sel][s], cas[sel][s], we[sel][s]};
                if (mon_code != NOP) begin
                    mon_cnt++;
                    mon_abs = cyc * 4 + s;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_cmd: got %b on slot %0d with nothing expected (t=%0t)",
                                 mon_code, s, $time);
                    end else begin
                        check("cmd_order", 32'(mon_code), 32'(exp_q.pop_front()));
                    end
                    if (last_sel == sel) begin
                        if (exact_gap != 0) begin
                            check("slot_gap", 32'(mon_abs - last_abs), 32'(exact_gap));
                        end else begin
                            n_checks++;
                            if (mon_abs - last_abs < longint'(spacing_of(sel))) begin
                                n_fail++;
                                $display("FAIL min_gap: got %0d expected at least %0d",
                                         mon_abs - last_abs, spacing_of(sel));
                            end
                        end
                    end
                    last_abs = mon_abs;
                    last_sel = sel;
                end
            end
            check("pack_count", 32'(pc[sel]), 32'(mon_cnt));
            if (log_en) we_log.push_back(we[sel]);
            if (chk_lvl) begin
                n_checks++;
                if (lvl[sel] > 3'd4) begin
                    n_fail++;
                    $display("FAIL level_bound: got %0d expected at most 4", lvl[sel]);
                end
                if (lvl[sel] == 3'd4) check("ready_at_full", 32'(rdy[sel]), 32'd0);
                if (int'(lvl[sel]) > max_lvl) max_lvl = int'(lvl[sel]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [2:0] c);
        bit got;
        got = 1'b0;
        vld[i]     = 1'b1;
        code_in[i] = c;
        for (int t = 0; t < 100 && !got; t++) begin
            got = rdy[i];
            if (got) exp_q.push_back(c);
            tick();
        end
        vld[i] = 1'b0;
        check("send_accepted", 32'(got), 32'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) tick();
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    logic [2:0] tbl [10];
    int         c_idx;

    initial begin
        tbl = '{ACT, RD, WR, PRE, REF, RD, WR, ACT, PRE, RD};
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            vld[i] = 1'b0;
            code_in[i] = NOP;
            oe_in[i] = 1'b0;
        end
        repeat (4) tick();

        // Reset values on all instances
        for (int i = 0; i < N; i++) begin
            check("rst_ras", 32'(ras[i]), 32'hF);
            check("rst_cas", 32'(cas[i]), 32'hF);
            check("rst_we", 32'(we[i]), 32'hF);
            check("rst_oe", 32'(oe_out[i]), 32'h0);
            check("rst_ready", 32'(rdy[i]), 32'd0);
            check("rst_pack", 32'(pc[i]), 32'd0);
            check("rst_level", 32'(lvl[i]), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(rdy[0]), 32'd0);
        tick();
        for (int i = 0; i < N; i++) check("ready_after_release", 32'(rdy[i]), 32'd1);

        // Single ACT, spacing 1, one-cycle latency
        sel = 0;
        send(0, ACT);
        check("act_latency_pack", 32'(pc[0]), 32'd0);
        tick();
        check("act_ras", 32'(ras[0]), 32'b1110);
        check("act_cas", 32'(cas[0]), 32'hF);
        check("act_we", 32'(we[0]), 32'hF);
        check("act_pack", 32'(pc[0]), 32'd1);
        send(0, RD);
        send(0, WR);
        send(0, PRE);
        send(0, REF);
        drain();

        // OE path, with traffic in flight
        oe_in[0] = 1'b1;
        check("oe_before_edge", 32'(oe_out[0]), 32'h0);
        send(0, RD);
        check("oe_high", 32'(oe_out[0]), 32'hF);
        oe_in[0] = 1'b0;
        tick();
        check("oe_low", 32'(oe_out[0]), 32'h0);
        drain();

        // Spacing carry across cycles, spacing 6
        sel = 1;
        exact_gap = 6;
        we_log.delete();
        log_en = 1'b1;
        send(1, WR);
        send(1, WR);
        send(1, WR);
        drain();
        repeat (2) tick();
        log_en = 1'b0;
        exact_gap = 0;
        c_idx = -1;
        for (int k = 0; k < we_log.size(); k++) begin
            if (c_idx < 0 && we_log[k] != 4'hF) c_idx = k;
        end
        if (c_idx < 0 || c_idx + 3 >= we_log.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_words: got %0d logged words expected WR pattern", we_log.size());
        end else begin
            check("wr_word_c0", 32'(we_log[c_idx]), 32'b1110);
            check("wr_word_c1", 32'(we_log[c_idx + 1]), 32'b1011);
            check("wr_word_c2", 32'(we_log[c_idx + 2]), 32'hF);
            check("wr_word_c3", 32'(we_log[c_idx + 3]), 32'b1110);
        end

        // Backpressure, spacing 15, CMD_VALID held
        sel = 2;
        exact_gap = 15;
        max_lvl = 0;
        chk_lvl = 1'b1;
        for (int k = 0; k < 10; k++) send(2, tbl[k]);
        drain();
        chk_lvl = 1'b0;
        exact_gap = 0;
        check("level_reached_full", 32'(max_lvl), 32'd4);

        // Mid-operation reset flushes the queue
        repeat (3) tick();
        send(2, ACT);
        send(2, RD);
        send(2, WR);
        check("queued_before_reset", 32'(lvl[2]), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        tick();
        check("flush_ras", 32'(ras[2]), 32'hF);
        check("flush_cas", 32'(cas[2]), 32'hF);
        check("flush_we", 32'(we[2]), 32'hF);
        check("flush_level", 32'(lvl[2]), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_pack", 32'(pc[2]), 32'd0);
        check("post_rst_level", 32'(lvl[2]), 32'd0);
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pf_ddr3_cmd_slot_packer.md
PF_DDR3_CMD_SLOT_PACKER -- requirements
Module: pf_ddr3_cmd_slot_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth; power of two, 2..16.
REQ-002 SHALL have parameter CMD_SPACING, default 1, minimum slot distance between issued commands; legal range 1..15.
REQ-003 SHALL run on one clock with a synchronous, active-high reset: FAB_CLK and TX_SYNC_RST.
REQ-004 FAB_CLK  in  1  fabric clock; one cycle = 4 command slots.
REQ-005 TX_SYNC_RST  in  1  synchronous active-high reset.
REQ-006 CMD_VALID  in  1  command offered.
REQ-007 CMD_READY  out  1  command accepted on an edge where CMD_VALID=1 and CMD_READY=1.
REQ-008 CMD_CODE  in  3  {RAS_N,CAS_N,WE_N}, active-low encoding; 3'b111 = NOP.
REQ-009 OE_ENABLE  in  1  pin drive enable from calibration logic.
REQ-010 RAS_N_DATA, CAS_N_DATA, WE_N_DATA  out  4 each  per-slot pin values; bit 0 = first slot on the wire; each feeds an IOD TX_DATA input.
REQ-011 OE_DATA  out  4  per-slot output enable to the IOD.
REQ-012 PACK_COUNT  out  3  number of commands placed in the current output word (0..4).
REQ-013 FIFO_LEVEL  out  clog2(FIFO_DEPTH+1)  queued entries, registered.

Function
REQ-014 Accepted commands SHALL enter a FIFO in order; at most one push per cycle.
REQ-015 The FIFO SHALL pop 0..4 entries per cycle, as decided by the packer.
REQ-016 CMD_READY SHALL be 1 iff not in reset and registered FIFO_LEVEL < FIFO_DEPTH.
- Independent of pops in the same cycle.
- Independent of CMD_VALID.
REQ-017 The packer SHALL hold a gap counter g (4 bits, registered) and evaluate slots 0..3 in order each cycle:
- If g==0 and an entry is available: issue the head entry in that slot, then set g=CMD_SPACING-1.
- Otherwise, if g>0: decrement g.
- Otherwise: hold g at 0.
- A slot with no issue carries NOP 3'b111.
REQ-018 The gap counter SHALL carry across cycle boundaries, so spacing is measured in absolute slots.
REQ-019 Only entries registered in the FIFO at the start of a cycle SHALL be eligible in that cycle.
- A command accepted at edge k is first eligible after edge k.
- Its output appears at edge k+1 at the earliest (1-cycle latency).
REQ-020 All outputs SHALL be registered; PACK_COUNT SHALL equal the number of non-NOP slots in the same word.
REQ-021 OE_DATA SHALL equal {4{OE_ENABLE}}, registered, with the same 1-cycle latency.
REQ-022 Simultaneous push and pops in one cycle SHALL update FIFO_LEVEL by +1-pops.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Command order SHALL be preserved.
REQ-025 No command SHALL be dropped or duplicated.
REQ-026 An empty FIFO SHALL produce all-NOP words; g still decrements toward 0.

Reset
REQ-027 While TX_SYNC_RST=1, at each edge the block SHALL set:
- RAS_N_DATA, CAS_N_DATA, WE_N_DATA = 4'hF.
- OE_DATA = 4'h0.
- PACK_COUNT = 0, FIFO_LEVEL = 0, g = 0.
- CMD_READY = 0.
REQ-028 Reset asserted mid-operation SHALL flush all queued commands; none SHALL appear after release.
REQ-029 CMD_READY SHALL rise on the first edge after TX_SYNC_RST deasserts.

Structure
REQ-030 A shared package SHALL hold:
- The command code constants NOP=3'b111, ACT=3'b011, RD=3'b101, WR=3'b100, PRE=3'b010, REF=3'b001.
- The slot count constant SLOTS=4.
REQ-031 The FIFO SHALL be one sub-module, pf_ddr3_cmd_fifo, with single push and multi-pop (0..4) ports.
- It exposes the head four entries combinationally from registered storage.

Verification
REQ-032 Reset check: TX_SYNC_RST held 3 cycles -> pin words 4'hF, OE_DATA 0, CMD_READY 0; CMD_READY=1 on the first edge after release.
REQ-033 Single command: CMD_SPACING=1, ACT (3'b011) accepted at edge k -> at edge k+1:
- RAS_N_DATA=4'b1110, CAS_N_DATA=4'hF, WE_N_DATA=4'hF, PACK_COUNT=1.
REQ-034 Spacing carry: CMD_SPACING=6, three WR (3'b100) accepted on consecutive edges, first output word at cycle c ->
- WE_N_DATA = 4'b1110 at c, 4'b1011 at c+1, 4'hF at c+2, 4'b1110 at c+3.
REQ-035 Backpressure: CMD_SPACING=15, CMD_VALID held high with a 10-command sequence ->
- FIFO_LEVEL never exceeds 4; CMD_READY=0 whenever level=4.
- All 10 commands emerge in order, each 15 slots apart.
REQ-036 Mid-operation reset: 3 commands queued (CMD_SPACING=15), TX_SYNC_RST pulsed for 1 cycle ->
- Next word is all-NOP with FIFO_LEVEL=0.
- No queued command appears afterwards.
REQ-037 OE path: OE_ENABLE toggled 0->1 at edge k -> OE_DATA=4'hF from edge k+1, independent of command traffic.
